// File: rtl/seq_divider.sv
// Sequential unsigned non-restoring divider: one add/subtract per clock on a
// (WIDTH+1)-bit signed accumulator, with a start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CORR, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH:0]   r_a, r_m;
  logic [WIDTH-1:0] r_q, r_quo, r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;

  logic [WIDTH:0]   w_a_sh, w_a_new, w_a_corr;
  logic [WIDTH-1:0] w_q_new;
  logic             w_last;

  // Shift {A,Q} left, then subtract M when A was non-negative, else add it back.
  assign w_a_sh   = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_a_new  = r_a[WIDTH] ? (w_a_sh + r_m) : (w_a_sh + ~r_m + (WIDTH+1)'(1));
  assign w_q_new  = {r_q[WIDTH-2:0], ~w_a_new[WIDTH]};
  assign w_a_corr = r_a[WIDTH] ? (r_a + r_m) : r_a;
  assign w_last   = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (y == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_CORR;
      S_CORR: w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (y == '0) begin
              r_quo <= '1;
              r_rem <= x;
              r_dbz <= 1'b1;
            end else begin
              r_a   <= '0;
              r_q   <= x;
              r_m   <= {1'b0, y};
              r_cnt <= '0;
              r_dbz <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_a   <= w_a_new;
          r_q   <= w_q_new;
          r_cnt <= r_cnt + CW'(1);
        end
        S_CORR: begin
          r_a   <= w_a_corr;
          r_quo <= r_q;
          r_rem <= w_a_corr[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign q    = r_quo;
  assign r    = r_rem;
  assign dbz  = r_dbz;
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed scenarios plus random operands
// compared against plain integer division.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = '0, y = '0;
  logic [7:0] q, r;
  logic       busy, done, dbz;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .q(q), .r(r), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Drives one operation; reports latency (edges after the accept edge until
  // done is seen), the outputs in the done cycle and handshake observations.
  task automatic do_op(input logic [7:0] ix, input logic [7:0] iy,
                       output int lat, output logic [7:0] oq, output logic [7:0] orr,
                       output logic odbz, output logic obusy0, output logic obusy_end,
                       output logic odone_after, output logic to);
    start = 1'b1; x = ix; y = iy;
    @(posedge clk); #1;
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom);
    obusy0 = busy;
    lat = 0; to = 1'b1;
    oq = '0; orr = '0; odbz = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i > 0 || !done) begin
        @(posedge clk); #1;
      end
      lat++;
      if (done) begin to = 1'b0; break; end
    end
    oq = q; orr = r; odbz = dbz;
    @(posedge clk); #1;
    obusy_end = busy;
    odone_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (q !== 8'd0)    begin n_err++; $display("FAIL reset_q: got %0d want 0", q); end
    n_cmp++; if (r !== 8'd0)    begin n_err++; $display("FAIL reset_r: got %0d want 0", r); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (dbz !== 1'b0)  begin n_err++; $display("FAIL reset_dbz: got %b want 0", dbz); end
  endtask

  task automatic test_basic;
    int lat; logic [7:0] oq, orr; logic od, b0, be, da, to;
    do_op(8'd200, 8'd7, lat, oq, orr, od, b0, be, da, to);
    n_cmp++; if (to)          begin n_err++; $display("FAIL basic_timeout: no done within 50 edges"); end
    n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %b want 1", b0); end
    n_cmp++; if (lat != 9)    begin n_err++; $display("FAIL basic_latency: got %0d want 9", lat); end
    n_cmp++; if (oq !== 8'd28 || orr !== 8'd4 || od !== 1'b0)
      begin n_err++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=28 r=4 dbz=0", oq, orr, od); end
    n_cmp++; if (be !== 1'b0) begin n_err++; $display("FAIL basic_busy_fall: got %b want 0", be); end
    n_cmp++; if (da !== 1'b0) begin n_err++; $display("FAIL basic_done_width: done still %b after one cycle", da); end
  endtask

  task automatic test_boundary;
    logic [7:0] tx [4] = '{8'd255, 8'd5, 8'd0, 8'd255};
    logic [7:0] ty [4] = '{8'd1,   8'd9, 8'd3, 8'd255};
    logic [7:0] eq [4] = '{8'd255, 8'd0, 8'd0, 8'd1};
    logic [7:0] er [4] = '{8'd0,   8'd5, 8'd0, 8'd0};
    int lat; logic [7:0] oq, orr; logic od, b0, be, da, to;
    for (int i = 0; i < 4; i++) begin
      do_op(tx[i], ty[i], lat, oq, orr, od, b0, be, da, to);
      n_cmp++;
      if (to || lat != 9 || oq !== eq[i] || orr !== er[i] || od !== 1'b0) begin
        n_err++;
        $display("FAIL boundary_%0d/%0d: got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=0 lat=9",
                 tx[i], ty[i], oq, orr, od, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_dbz;
    int lat; logic [7:0] oq, orr; logic od, b0, be, da, to;
    do_op(8'd77, 8'd0, lat, oq, orr, od, b0, be, da, to);
    n_cmp++; if (to || lat != 1) begin n_err++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    n_cmp++; if (oq !== 8'hFF || orr !== 8'd77 || od !== 1'b1)
      begin n_err++; $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=77 dbz=1", oq, orr, od); end
    do_op(8'd9, 8'd3, lat, oq, orr, od, b0, be, da, to);
    n_cmp++; if (to || lat != 9 || oq !== 8'd3 || orr !== 8'd0 || od !== 1'b0)
      begin n_err++; $display("FAIL dbz_clear: got q=%0d r=%0d dbz=%b lat=%0d want q=3 r=0 dbz=0 lat=9", oq, orr, od, lat); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2; logic to1, to2;
    start = 1'b1; x = 8'd100; y = 8'd3;
    @(posedge clk); #1;
    x = 8'd50; y = 8'd5;
    lat1 = 0; to1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1; lat1++;
      if (done) begin to1 = 1'b0; break; end
    end
    n_cmp++; if (to1 || lat1 != 9 || q !== 8'd33 || r !== 8'd1)
      begin n_err++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d want q=33 r=1 lat=9", q, r, lat1); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap: busy=%b want 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_accept: busy=%b want 1", busy); end
    start = 1'b0;
    lat2 = 0; to2 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1; lat2++;
      if (done) begin to2 = 1'b0; break; end
    end
    n_cmp++; if (to2 || lat2 != 9 || q !== 8'd10 || r !== 8'd0)
      begin n_err++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d want q=10 r=0 lat=9", q, r, lat2); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] oq, orr; logic od, b0, be, da, to;
    logic saw_done;
    start = 1'b1; x = 8'd200; y = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (q !== 8'd0 || r !== 8'd0 || dbz !== 1'b0)
      begin n_err++; $display("FAIL rstmid_outputs: got q=%0d r=%0d dbz=%b want 0/0/0", q, r, dbz); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_err++; $display("FAIL rstmid_state: busy=%b done=%b want 0/0", busy, done); end
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done) begin n_err++; $display("FAIL rstmid_no_done: activity after reset got 1 want 0"); end
    do_op(8'd13, 8'd4, lat, oq, orr, od, b0, be, da, to);
    n_cmp++; if (to || lat != 9 || oq !== 8'd3 || orr !== 8'd1 || od !== 1'b0)
      begin n_err++; $display("FAIL rstmid_restart: got q=%0d r=%0d lat=%0d want q=3 r=1 lat=9", oq, orr, lat); end
  endtask

  task automatic test_random;
    int lat; logic [7:0] oq, orr; logic od, b0, be, da, to;
    logic [7:0] rx, ry;
    int bad_res = 0, bad_lat = 0;
    for (int i = 0; i < 500; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom_range(255, 1));
      do_op(rx, ry, lat, oq, orr, od, b0, be, da, to);
      n_cmp++;
      if (oq !== 8'(int'(rx) / int'(ry)) || orr !== 8'(int'(rx) % int'(ry)) ||
          int'(oq) * int'(ry) + int'(orr) != int'(rx) || orr >= ry || od !== 1'b0) begin
        n_err++;
        if (bad_res++ < 5)
          $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d want q=%0d r=%0d",
                   rx, ry, oq, orr, int'(rx) / int'(ry), int'(rx) % int'(ry));
      end
      n_cmp++;
      if (to || lat != 9) begin
        n_err++;
        if (bad_lat++ < 5) $display("FAIL rand_latency %0d/%0d: got %0d want 9", rx, ry, lat);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_boundary();
    test_dbz();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned non-restoring divider for the ALU, the inverse operation to the 9-bit parallel add/subtract datapath.
- Divides a WIDTH-bit dividend by a WIDTH-bit divisor using a (WIDTH+1)-bit signed accumulator: one add or subtract per clock.
- Returns quotient and remainder under a start/busy/done handshake.
- Sits beside the adder in the ALU execute path; the ALU control FSM issues start and waits for done.

Parameters:
- WIDTH, 8, operand/quotient/remainder width; accumulator is WIDTH+1 bits (sign + magnitude, 9 bits at default).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- x  input  WIDTH  dividend, captured on the accepted start edge
- y  input  WIDTH  divisor, captured on the accepted start edge
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle result-valid pulse
- dbz  output  1  divide-by-zero flag, valid with done

Behaviour:
- Reset (rst high at a clock edge, overrides everything including an in-flight operation): state=IDLE; q=0, r=0, busy=0, done=0, dbz=0; accumulator A=0, shift register Q=0, M=0, cnt=0.
- States: IDLE, RUN, CORR, DONE.
- IDLE, start=1, y!=0: load A=0, Q=x, M={0,y}, cnt=0, clear dbz; go to RUN.
- IDLE, start=1, y==0: q=all-ones, r=x, dbz=1; go to DONE. No iterations are performed.
- IDLE, start=0: hold all state.
- RUN, one iteration per edge:
  - Shift {A,Q} left by one.
  - If the pre-shift A[WIDTH]==0, A=A-M (two's complement: A + ~M + 1); otherwise A=A+M.
  - Q[0] = ~newA[WIDTH].
  - cnt increments each edge; after the iteration with cnt==WIDTH-1, go to CORR.
- CORR: if A[WIDTH]==1, A=A+M. Then q=Q, r=A[WIDTH-1:0]; go to DONE.
- DONE: done=1 for exactly this one cycle; go to IDLE on the next edge.
- Latency:
  - Normal divide: done is high in the cycle after the (WIDTH+1)-th edge following the start-sampling edge, i.e. the 9th edge at default.
  - Divide by zero: done is high in the cycle after the start-sampling edge.
- busy rises on the edge that accepts start and falls on the edge leaving DONE.
- start is ignored in RUN, CORR and DONE. No queuing: a start held high in the DONE cycle is not accepted; it is accepted on the first IDLE cycle after DONE.
- x and y may change freely after the accepted start edge; the result depends only on the captured values.
- q, r and dbz hold their values from DONE until the next accepted start, or until reset.
- Arithmetic:
  - The accumulator is WIDTH+1 bits wide; carry out of the MSB is discarded.
  - Invariant: x == q*y + r and r < y for every y != 0.
  - Edge values are handled without special cases: x=0 gives q=0, r=0; x < y gives q=0, r=x; y=1 gives q=x, r=0; x=y gives q=1, r=0.
- Reset mid-operation: the operation is abandoned with no done pulse. The next start begins from clean state.

Test Plan:
- Reset, then start with x=200, y=7 -> busy=1 from the next cycle; done pulses one cycle, 9 edges after the start edge; q=28, r=4, dbz=0; busy=0 after the done cycle.
- Boundary operands, run back to back:
  - x=255, y=1 -> q=255, r=0.
  - x=5, y=9 -> q=0, r=5.
  - x=0, y=3 -> q=0, r=0.
  - x=255, y=255 -> q=1, r=0.
- x=77, y=0 -> done high in the cycle after the start edge; dbz=1, q=8'hFF, r=77. A following x=9, y=3 clears dbz and gives q=3, r=0.
- Hold start high continuously with x=100, y=3 (first result q=33, r=1), and change x/y to 50/5 mid-operation -> first result unaffected by the change; a second operation starts only after the DONE cycle, giving q=10, r=0. No overlap, and no start is accepted during busy.
- Assert rst for one edge at iteration 4 of x=200, y=7 -> all outputs 0, state IDLE, no done pulse. A new start with x=13, y=4 then completes normally with q=3, r=1.
- Random regression: 500 random (x, y) pairs with y != 0 -> q*y + r == x, r < y, and done latency exactly 9 edges, checked against a behavioural model.
